stepper_sequencer: RTL and testbench

STEPPER_SEQUENCER -- requirements
Module: stepper_sequencer

---
 rtl/stepper_sequencer.sv | 175 +++++++++++++++++
 tb/tb_stepper_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_sequencer.sv
// rtl/stepper_sequencer.sv - stepper motor coil sequencer with synchronised step-rate input
// Build option: define HALF_STEP_EN for the 8-phase half-step table (default: 4-phase full-step).
module stepper_sequencer #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_clk,
  input  logic               start,
  input  logic               dir,
  input  logic [COUNT_W-1:0] step_count,
  input  logic               abort,
  output logic [3:0]         coil,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] steps_done
);

`ifdef HALF_STEP_EN
  localparam int IDX_W = 3;
`else
  localparam int IDX_W = 2;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t state_q, state_d;

  logic               s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]         warm_q, warm_d;
  logic               armed_q, armed_d;
  logic               tick;

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         coil_q, coil_d;
  logic               dir_q, dir_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [COUNT_W-1:0] steps_done_q, steps_done_d;
  logic               done_q, done_d;

  function automatic logic [3:0] phase_pattern(input logic [IDX_W-1:0] idx);
    logic [3:0] pat;
`ifdef HALF_STEP_EN
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
`else
    case (idx)
      2'd0:    pat = 4'b1100;
      2'd1:    pat = 4'b0110;
      2'd2:    pat = 4'b0011;
      default: pat = 4'b1001;
    endcase
`endif
    return pat;
  endfunction

  // Synchroniser chain plus arming: a step_clk level already high when reset
  // releases must be seen low once (after the chain holds real samples) before
  // any rising edge counts as a tick.
  always_comb begin
    s1_d    = step_clk;
    s2_d    = s1_q;
    s3_d    = s2_q;
    warm_d  = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    armed_d = armed_q | ((warm_q == 2'd2) & ~s2_q);
    tick    = s2_q & ~s3_q & armed_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks a coincident tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (step_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tick && (remaining_q == COUNT_W'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: move setup, phase stepping, coil drive and step counting
  always_comb begin
    idx_d        = idx_q;
    coil_d       = coil_q;
    dir_d        = dir_q;
    remaining_d  = remaining_q;
    steps_done_d = steps_done_q;
    done_d       = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d        = dir;
          remaining_d  = step_count;
          steps_done_d = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          coil_d = 4'b0000;
        end else if (tick) begin
          idx_d        = dir_q ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
          coil_d       = phase_pattern(idx_d);
          remaining_d  = remaining_q - COUNT_W'(1);
          steps_done_d = steps_done_q + COUNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and synchroniser registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      warm_q       <= 2'd0;
      armed_q      <= 1'b0;
      idx_q        <= '0;
      coil_q       <= 4'b0000;
      dir_q        <= 1'b0;
      remaining_q  <= '0;
      steps_done_q <= '0;
      done_q       <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      warm_q       <= warm_d;
      armed_q      <= armed_d;
      idx_q        <= idx_d;
      coil_q       <= coil_d;
      dir_q        <= dir_d;
      remaining_q  <= remaining_d;
      steps_done_q <= steps_done_d;
      done_q       <= done_d;
    end
  end

  // Output mapping
  always_comb begin
    coil       = coil_q;
    busy       = (state_q == ST_RUN);
    done       = done_q;
    steps_done = steps_done_q;
  end

endmodule

// File: tb/tb_stepper_sequencer.sv
// tb/tb_stepper_sequencer.sv - scoreboard bench for stepper_sequencer
module tb_stepper_sequencer;

  localparam int CW = 16;
  localparam logic [1:0] EV_COIL  = 2'd0;
  localparam logic [1:0] EV_BFALL = 2'd1;
  localparam logic [1:0] EV_DONE  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          step_clk = 1'b0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [CW-1:0] step_count = '0;
  logic          abort = 1'b0;
  logic [3:0]    coil;
  logic          busy;
  logic          done;
  logic [CW-1:0] steps_done;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  stepper_sequencer #(.COUNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .step_clk   (step_clk),
    .start      (start),
    .dir        (dir),
    .step_count (step_count),
    .abort      (abort),
    .coil       (coil),
    .busy       (busy),
    .done       (done),
    .steps_done (steps_done)
  );

  always #5 clk = ~clk;

  function automatic string kname(input logic [1:0] k);
    case (k)
      EV_COIL:  return "coil";
      EV_BFALL: return "busy_fall_steps_done";
      default:  return "done_steps_done";
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input logic [15:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic push_coils(input logic [3:0] c0, input logic [3:0] c1, input int n);
    push(EV_COIL, {12'b0, c0});
    if (n > 1) push(EV_COIL, {12'b0, c1});
  endtask

  task automatic observe(input logic [1:0] k, input logic [15:0] v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s actual=%h required=no_event", kname(k), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.val !== v) begin
        errors++;
        $display("FAIL %s actual=%h required=%s:%h", kname(k), v, kname(e.kind), e.val);
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic start_move(input logic d, input logic [CW-1:0] n);
    start = 1'b1;
    dir = d;
    step_count = n;
    cyc(1);
    start = 1'b0;
  endtask

  // step_clk high 4 cycles, low 4; optional abort on the cycle the tick is high
  task automatic pulse(input bit abort_on_tick);
    step_clk = 1'b1;
    cyc(2);
    if (abort_on_tick) begin
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      cyc(1);
    end else begin
      cyc(2);
    end
    step_clk = 1'b0;
    cyc(4);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      cyc(1);
      n++;
    end
    cyc(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s actual=%0d_pending required=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: reset values, then every coil change / busy fall / done cycle
  initial begin
    logic [3:0] prev_coil;
    logic       prev_busy;
    repeat (2) @(negedge clk);
    chk("rst_coil", {12'b0, coil}, 16'h0000);
    chk("rst_busy", {15'b0, busy}, 16'h0000);
    chk("rst_done", {15'b0, done}, 16'h0000);
    chk("rst_steps_done", steps_done, 16'h0000);
    prev_coil = coil;
    prev_busy = busy;
    forever begin
      @(negedge clk);
      if (coil !== prev_coil) observe(EV_COIL, {12'b0, coil});
      if (prev_busy && !busy) observe(EV_BFALL, steps_done);
      if (done) observe(EV_DONE, steps_done);
      prev_coil = coil;
      prev_busy = busy;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] pat1;
`ifdef HALF_STEP_EN
    logic [3:0] half_tbl [0:7];
    half_tbl[0] = 4'b1000; half_tbl[1] = 4'b1100; half_tbl[2] = 4'b0100; half_tbl[3] = 4'b0110;
    half_tbl[4] = 4'b0010; half_tbl[5] = 4'b0011; half_tbl[6] = 4'b0001; half_tbl[7] = 4'b1001;
    pat1 = 4'b1100;
`else
    pat1 = 4'b0110;
`endif
    cyc(4);
    rst = 1'b0;
    cyc(2);

`ifdef HALF_STEP_EN
    // nine forward half-steps from index 0: wraps 7 -> 0 -> 1
    for (int i = 1; i <= 9; i++) push(EV_COIL, {12'b0, half_tbl[i % 8]});
    push(EV_BFALL, 16'd9);
    push(EV_DONE, 16'd9);
    start_move(1'b1, 16'd9);
    for (int i = 0; i < 9; i++) pulse(1'b0);
    drain("half_fwd9");
    push(EV_COIL, 16'h0000);
    rst = 1'b1; cyc(1); rst = 1'b0;
    drain("half_reset");
`else
    // forward 3 from index 0
    push_coils(4'b0110, 4'b0011, 2);
    push(EV_COIL, 16'b1001);
    push(EV_BFALL, 16'd3);
    push(EV_DONE, 16'd3);
    start_move(1'b1, 16'd3);
    for (int i = 0; i < 3; i++) pulse(1'b0);
    drain("fwd3");

    // reset then reverse 2: index 0 -> 3 -> 2
    push(EV_COIL, 16'h0000);
    rst = 1'b1; cyc(1); rst = 1'b0;
    push_coils(4'b1001, 4'b0011, 2);
    push(EV_BFALL, 16'd2);
    push(EV_DONE, 16'd2);
    start_move(1'b0, 16'd2);
    for (int i = 0; i < 2; i++) pulse(1'b0);
    drain("rev2");

    // zero-length move: done only, steps_done cleared, coil held
    push(EV_DONE, 16'd0);
    start_move(1'b1, 16'd0);
    drain("zero");

    // forward 10 from index 2, abort on the 4th tick
    push_coils(4'b1001, 4'b1100, 2);
    push(EV_COIL, 16'b0110);
    push(EV_COIL, 16'h0000);
    push(EV_BFALL, 16'd3);
    start_move(1'b1, 16'd10);
    for (int i = 0; i < 3; i++) pulse(1'b0);
    pulse(1'b1);
    drain("abort");

    // forward 10 from index 1 (after abort), start ignored mid-move, reset after 5
    push_coils(4'b0011, 4'b1001, 2);
    push_coils(4'b1100, 4'b0110, 2);
    push(EV_COIL, 16'b0011);
    push(EV_COIL, 16'h0000);
    push(EV_BFALL, 16'd0);
    start_move(1'b1, 16'd10);
    pulse(1'b0);
    pulse(1'b0);
    start_move(1'b0, 16'd0);
    for (int i = 0; i < 3; i++) pulse(1'b0);
    rst = 1'b1; cyc(1); rst = 1'b0;
    drain("reset_mid_move");

    // one step after reset starts from index 0
    push(EV_COIL, {12'b0, pat1});
    push(EV_BFALL, 16'd1);
    push(EV_DONE, 16'd1);
    start_move(1'b1, 16'd1);
    pulse(1'b0);
    drain("one_after_reset");
    push(EV_COIL, 16'h0000);
`endif

    // step_clk held high through reset must not tick until it falls and rises
    step_clk = 1'b1;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    start_move(1'b1, 16'd1);
    cyc(8);
    step_clk = 1'b0;
    cyc(4);
    drain("held_high_quiet");
    push(EV_COIL, {12'b0, pat1});
    push(EV_BFALL, 16'd1);
    push(EV_DONE, 16'd1);
    pulse(1'b0);
    drain("held_high_step");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
